matrix_loader: RTL

Stream-to-matrix deserializer that feeds the A or B operand port of `matrix_multiplier`. Accepts IEEE-754 single-precision words one at a time over a stb/ack handshake, packs them into the flat operand bus used by the multiplier, then presents the complete matrix with its own stb/ack handshake. One instance per operand. The block replaces the testbench ROM-to-bus loops in the integrated datapath.

---
 rtl/matrix_pkg.sv | 19 +
 rtl/matrix_index_gen.sv | 63 ++++++
 rtl/matrix_loader.sv | 93 +++++++++
 3 files changed

// File: rtl/matrix_pkg.sv
// matrix_pkg: shared definitions for the matrix operand datapath.
//   FLOAT_W         - width of one IEEE-754 single-precision element
//   loader_state_t  - matrix_loader FSM states (IDLE/LOAD/PRESENT)
//   cnt_width()     - bit width needed to count 0..n-1 (minimum 1)
package matrix_pkg;

    localparam int FLOAT_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        PRESENT
    } loader_state_t;

    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/matrix_index_gen.sv
// matrix_index_gen: row/column counters that walk the slots of a rows x cols
// matrix, one step per accepted word, and return to (0,0) after the last slot.
// Ordering: row-major stream by default (c advances first); when
// MATRIX_LOADER_TRANSPOSE_EN is defined the stream is column-major (r advances
// first). The slot index is always the row-major position r*cols+c.
// Ports:
//   clk, rst  - clock, synchronous active-high reset (counters to 0)
//   advance   - step to the next slot on this edge
//   slot      - row-major slot index addressed by the current counters
//   last      - current slot is the final one of the matrix
module matrix_index_gen
    import matrix_pkg::*;
#(
    parameter int rows = 2,
    parameter int cols = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               advance,
    output logic [cnt_width(rows*cols)-1:0]    slot,
    output logic                               last
);

    localparam int RW     = cnt_width(rows);
    localparam int CW     = cnt_width(cols);
    localparam int SLOT_W = cnt_width(rows * cols);

    logic [RW-1:0] r;
    logic [CW-1:0] c;
    logic          r_end;
    logic          c_end;

    assign r_end = (r == RW'(rows - 1));
    assign c_end = (c == CW'(cols - 1));
    assign last  = r_end && c_end;
    assign slot  = SLOT_W'(int'(r) * cols + int'(c));

    always_ff @(posedge clk) begin
        if (rst) begin
            r <= '0;
            c <= '0;
        end else if (advance) begin
            if (last) begin
                r <= '0;
                c <= '0;
`ifdef MATRIX_LOADER_TRANSPOSE_EN
            end else if (r_end) begin
                r <= '0;
                c <= c + CW'(1);
            end else begin
                r <= r + RW'(1);
`else
            end else if (c_end) begin
                c <= '0;
                r <= r + RW'(1);
            end else begin
                c <= c + CW'(1);
`endif
            end
        end
    end

endmodule

// File: rtl/matrix_loader.sv
// matrix_loader: stream-to-matrix deserializer for one matrix_multiplier
// operand. Accepts 32-bit words over in_stb/in_ack, packs them into the flat
// operand bus, then presents the full matrix over out_stb/out_ack.
// Optional build macro: MATRIX_LOADER_TRANSPOSE_EN (column-major input stream).
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   in_data     - IEEE-754 single word, transported unmodified
//   in_stb      - upstream word valid
//   in_ack      - loader ready; transfer on in_stb && in_ack
//   matrix_out  - flat matrix, element (r,c) at [32*(r*cols+c) +: 32]
//   out_stb     - matrix complete and valid
//   out_ack     - consumer accepted; handoff on out_stb && out_ack
module matrix_loader
    import matrix_pkg::*;
#(
    parameter int rows = 2,
    parameter int cols = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [FLOAT_W-1:0]                in_data,
    input  logic                              in_stb,
    output logic                              in_ack,
    output logic [0:FLOAT_W*rows*cols-1]      matrix_out,
    output logic                              out_stb,
    input  logic                              out_ack
);

    localparam int NUM    = rows * cols;
    localparam int SLOT_W = cnt_width(NUM);

    loader_state_t     state;
    logic              xfer;
    logic [SLOT_W-1:0] slot;
    logic              last;

    // in_ack is only high in LOAD, so this is exactly a LOAD-state transfer.
    assign xfer = in_stb && in_ack;

    matrix_index_gen #(
        .rows (rows),
        .cols (cols)
    ) u_index (
        .clk     (clk),
        .rst     (rst),
        .advance (xfer),
        .slot    (slot),
        .last    (last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            in_ack     <= 1'b0;
            out_stb    <= 1'b0;
            matrix_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state  <= LOAD;
                    in_ack <= 1'b1;
                end
                LOAD: begin
                    if (xfer) begin
                        for (int unsigned i = 0; i < NUM; i++) begin
                            if (slot == SLOT_W'(i)) begin
                                matrix_out[FLOAT_W*i +: FLOAT_W] <= in_data;
                            end
                        end
                        if (last) begin
                            state   <= PRESENT;
                            in_ack  <= 1'b0;
                            out_stb <= 1'b1;
                        end
                    end
                end
                PRESENT: begin
                    if (out_ack) begin
                        state   <= LOAD;
                        out_stb <= 1'b0;
                        in_ack  <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    in_ack  <= 1'b0;
                    out_stb <= 1'b0;
                end
            endcase
        end
    end

endmodule
